mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit_pkg.sv | 40 ++++
 rtl/mem_access_unit_if.sv | 24 ++
 rtl/mem_access_unit_load_align.sv | 29 ++
 rtl/mem_access_unit.sv | 85 ++++++++
 tb/tb_mem_access_unit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: bus size codes,
// controller state encoding and the alignment/lane helpers.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_DATA = 2'd1;
  localparam logic [1:0] ST_DONE      = 2'd2;
  localparam logic [1:0] ST_DISCARD   = 2'd3;

  // The reserved size code behaves as a word, alignment included.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addrLo[0];
      default: bad = (addrLo != 2'b00);
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] laneReplicate(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] lanes;
    lanes = wd;
    case (size)
      SZ_BYTE: lanes = {4{wd[7:0]}};
      SZ_HALF: lanes = {2{wd[15:0]}};
      default: lanes = wd;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// SRAM-like split-handshake data bus: request/address phase then data phase.
interface mem_access_unit_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          data_req;
  logic          data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Selects the addressed byte/half lane of a load word and sign- or zero-extends it.
module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rdata,
  input  logic [1:0]    addrLo,
  input  logic [1:0]    size,
  input  logic          signedLoad,
  output logic [DW-1:0] result
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    byteSel = rdata[{addrLo, 3'b000} +: 8];
    halfSel = addrLo[1] ? rdata[31:16] : rdata[15:0];
    result  = rdata;
    case (size)
      SZ_BYTE: result = {{(DW-8){signedLoad & byteSel[7]}}, byteSel};
      SZ_HALF: result = {{(DW-16){signedLoad & halfSel[15]}}, halfSel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// ME-stage data-memory access unit: issues one bus transaction per load/store,
// stalls the pipe while it is outstanding and returns the extended load data.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memenM,
  input  logic          memwriteM,
  input  logic [1:0]    sizeM,
  input  logic          signedloadM,
  input  logic [AW-1:0] aluoutM,
  input  logic [DW-1:0] writedataM,
  input  logic          stallM,
  input  logic          flushM,
  output logic          mem_stall,
  output logic [DW-1:0] readdataM,
  output logic          adelM,
  output logic          adesM,
  mem_access_unit_if.master dataBus
);

  logic [1:0]    state;
  logic [1:0]    stateNext;
  logic [DW-1:0] rdataBuf;
  logic          misaligned;
  logic          valid;
  logic          inIdle;

  assign misaligned = isMisaligned(sizeM, aluoutM[1:0]);
  assign valid      = memenM & ~misaligned & ~flushM;
  assign inIdle     = (state == ST_IDLE);

  // Outputs are forced low while rst is held so a mid-transaction reset
  // silences the unit immediately rather than at the next edge.
  assign adelM     = ~rst & memenM & ~memwriteM & misaligned;
  assign adesM     = ~rst & memenM &  memwriteM & misaligned;
  assign mem_stall = ~rst & ((inIdle & valid) | (state == ST_WAIT_DATA) | (state == ST_DISCARD));

  assign dataBus.data_req   = ~rst & inIdle & valid;
  assign dataBus.data_wr    = memwriteM;
  assign dataBus.data_size  = sizeM;
  assign dataBus.data_addr  = aluoutM;
  assign dataBus.data_wdata = laneReplicate(sizeM, writedataM);

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:
        if (dataBus.data_req & dataBus.data_addr_ok) stateNext = ST_WAIT_DATA;
      ST_WAIT_DATA:
        // A flush landing on the data_ok cycle simply completes and drops the data.
        if (dataBus.data_data_ok)  stateNext = flushM ? ST_IDLE : ST_DONE;
        else if (flushM)           stateNext = ST_DISCARD;
      ST_DISCARD:
        if (dataBus.data_data_ok)  stateNext = ST_IDLE;
      ST_DONE:
        if (~stallM | flushM)      stateNext = ST_IDLE;
      default:                     stateNext = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rdataBuf <= '0;
    end else begin
      state <= stateNext;
      if ((state == ST_WAIT_DATA) && dataBus.data_data_ok) rdataBuf <= dataBus.data_rdata;
    end
  end

  mem_access_unit_load_align #(.DW(DW)) u_load_align (
    .rdata      (rdataBuf),
    .addrLo     (aluoutM[1:0]),
    .size       (sizeM),
    .signedLoad (signedloadM),
    .result     (readdataM)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// transactions against a behavioural model of the load/store rules.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        memenM, memwriteM, signedloadM, stallM, flushM;
  logic [1:0]  sizeM;
  logic [31:0] aluoutM, writedataM;
  logic        mem_stall, adelM, adesM;
  logic [31:0] readdataM;

  int          nVec = 0;
  int          nErr = 0;
  logic [31:0] expBuf = 32'h0;

  mem_access_unit_if #(.AW(32), .DW(32)) bus ();

  mem_access_unit #(.AW(32), .DW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .memenM      (memenM),
    .memwriteM   (memwriteM),
    .sizeM       (sizeM),
    .signedloadM (signedloadM),
    .aluoutM     (aluoutM),
    .writedataM  (writedataM),
    .stallM      (stallM),
    .flushM      (flushM),
    .mem_stall   (mem_stall),
    .readdataM   (readdataM),
    .adelM       (adelM),
    .adesM       (adesM),
    .dataBus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] refLoad(input logic [1:0] sz, input logic sgn,
                                          input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * addr[1:0])) & 32'hFF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * addr[1])) & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [31:0] refWdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  task automatic idle_inputs();
    memenM = 0; memwriteM = 0; sizeM = 2'd2; signedloadM = 0;
    aluoutM = 32'h0; writedataM = 32'h0; stallM = 0; flushM = 0;
    bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    memenM = 1; sizeM = 2'd2; aluoutM = 32'h100;
    @(negedge clk); #1;
    nVec++; if (mem_stall !== 1'b0) begin nErr++; $display("FAIL reset_stall got=%b exp=0", mem_stall); end
    nVec++; if (bus.data_req !== 1'b0) begin nErr++; $display("FAIL reset_req got=%b exp=0", bus.data_req); end
    nVec++; if (readdataM !== 32'h0) begin nErr++; $display("FAIL reset_rdata got=%h exp=0", readdataM); end
    aluoutM = 32'h102; #1;
    nVec++; if (adelM !== 1'b0) begin nErr++; $display("FAIL reset_adel got=%b exp=0", adelM); end
    @(negedge clk);
    rst = 0; memenM = 0;
    expBuf = 32'h0;
  endtask

  // One full transaction: addr_ok after aok waiting request cycles, data_ok
  // after dok idle cycles in the data phase, then DONE held hold cycles.
  task automatic run_xfer(input string name, input logic wr, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input int aok, input int dok, input int hold);
    int stallCnt = 0, reqCnt = 0, waitA = 0, waitD = 0;
    bit accepted = 0, gotData = 0, seenReq = 0, done = 0;
    logic [31:0] expLoad;
    expLoad = refLoad(sz, sgn, addr, rd);
    @(negedge clk);
    memenM = 1; memwriteM = wr; sizeM = sz; signedloadM = sgn;
    aluoutM = addr; writedataM = wd; stallM = 1; flushM = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.data_addr_ok = !accepted && (waitA >= aok);
      bus.data_data_ok = accepted && !gotData && (waitD >= dok);
      bus.data_rdata   = bus.data_data_ok ? rd : $urandom();
      #1;
      if (!mem_stall) begin done = 1; break; end
      stallCnt++;
      if (bus.data_req) begin
        reqCnt++;
        if (!seenReq) begin
          seenReq = 1;
          nVec++; if (bus.data_wr !== wr) begin nErr++; $display("FAIL %s bus_wr got=%b exp=%b", name, bus.data_wr, wr); end
          nVec++; if (bus.data_size !== sz) begin nErr++; $display("FAIL %s bus_size got=%0d exp=%0d", name, bus.data_size, sz); end
          nVec++; if (bus.data_addr !== addr) begin nErr++; $display("FAIL %s bus_addr got=%h exp=%h", name, bus.data_addr, addr); end
          nVec++; if (bus.data_wdata !== refWdata(sz, wd)) begin nErr++; $display("FAIL %s bus_wdata got=%h exp=%h", name, bus.data_wdata, refWdata(sz, wd)); end
        end
      end
      if (!accepted) begin
        if (bus.data_req && bus.data_addr_ok) accepted = 1; else waitA++;
      end else if (!gotData) begin
        if (bus.data_data_ok) gotData = 1; else waitD++;
      end
      @(negedge clk);
    end
    bus.data_addr_ok = 0; bus.data_data_ok = 0;
    nVec++; if (!done) begin nErr++; $display("FAIL %s timeout got=stall_stuck exp=release", name); end
    nVec++; if (stallCnt != aok + dok + 2) begin nErr++; $display("FAIL %s stall_cycles got=%0d exp=%0d", name, stallCnt, aok + dok + 2); end
    nVec++; if (reqCnt != aok + 1) begin nErr++; $display("FAIL %s req_cycles got=%0d exp=%0d", name, reqCnt, aok + 1); end
    if (!wr) begin
      nVec++; if (readdataM !== expLoad) begin nErr++; $display("FAIL %s rdata got=%h exp=%h", name, readdataM, expLoad); end
    end
    expBuf = rd;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      nVec++; if (bus.data_req !== 1'b0) begin nErr++; $display("FAIL %s hold_req got=%b exp=0", name, bus.data_req); end
      nVec++; if (mem_stall !== 1'b0) begin nErr++; $display("FAIL %s hold_stall got=%b exp=0", name, mem_stall); end
      if (!wr) begin
        nVec++; if (readdataM !== expLoad) begin nErr++; $display("FAIL %s hold_rdata got=%h exp=%h", name, readdataM, expLoad); end
      end
    end
    memenM = 0; stallM = 0;
    @(negedge clk); #1;
    nVec++; if (mem_stall !== 1'b0 || bus.data_req !== 1'b0) begin nErr++; $display("FAIL %s after_release got=stall%b/req%b exp=0/0", name, mem_stall, bus.data_req); end
  endtask

  task automatic test_misaligned(input string name, input logic wr, input logic [1:0] sz, input logic [31:0] addr);
    @(negedge clk);
    memenM = 1; memwriteM = wr; sizeM = sz; aluoutM = addr; stallM = 0; flushM = 0;
    bus.data_addr_ok = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      nVec++; if (adelM !== !wr) begin nErr++; $display("FAIL %s adel got=%b exp=%b", name, adelM, !wr); end
      nVec++; if (adesM !== wr) begin nErr++; $display("FAIL %s ades got=%b exp=%b", name, adesM, wr); end
      nVec++; if (bus.data_req !== 1'b0 || mem_stall !== 1'b0) begin nErr++; $display("FAIL %s no_req got=req%b/stall%b exp=0/0", name, bus.data_req, mem_stall); end
      @(negedge clk);
    end
    memenM = 0; bus.data_addr_ok = 0;
  endtask

  task automatic test_directed();
    run_xfer("lw_100", 0, 2'd2, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    run_xfer("lb_103", 0, 2'd0, 1, 32'h103, 32'h0, 32'h80FF_0011, 0, 0, 0);
    run_xfer("lbu_103", 0, 2'd0, 0, 32'h103, 32'h0, 32'h80FF_0011, 0, 0, 0);
    run_xfer("lh_102", 0, 2'd1, 1, 32'h102, 32'h0, 32'h9ABC_1234, 1, 2, 0);
    run_xfer("sh_202", 1, 2'd1, 0, 32'h202, 32'h1234_ABCD, 32'h5555_AAAA, 0, 0, 0);
    run_xfer("sb_201", 1, 2'd0, 0, 32'h201, 32'h1234_ABCD, 32'h0, 0, 1, 0);
    run_xfer("lw_hold4", 0, 2'd2, 0, 32'h180, 32'h0, 32'h0BAD_F00D, 0, 0, 4);
  endtask

  task automatic test_misaligned_all();
    test_misaligned("lw_102", 0, 2'd2, 32'h102);
    test_misaligned("sw_101", 1, 2'd2, 32'h101);
    test_misaligned("lh_301", 0, 2'd1, 32'h301);
  endtask

  task automatic test_discard();
    logic [31:0] junk;
    junk = $urandom() | 32'h1;
    @(negedge clk);
    memenM = 1; memwriteM = 0; sizeM = 2'd2; signedloadM = 0; aluoutM = 32'h300;
    stallM = 1; flushM = 0; bus.data_addr_ok = 1;
    #1;
    nVec++; if (bus.data_req !== 1'b1) begin nErr++; $display("FAIL discard_req got=%b exp=1", bus.data_req); end
    @(negedge clk);
    bus.data_addr_ok = 0; flushM = 1;
    #1;
    nVec++; if (mem_stall !== 1'b1) begin nErr++; $display("FAIL discard_wait_stall got=%b exp=1", mem_stall); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      flushM = 0;
      bus.data_data_ok = (c == 2);
      bus.data_rdata = junk;
      #1;
      nVec++; if (mem_stall !== 1'b1) begin nErr++; $display("FAIL discard_stall%0d got=%b exp=1", c, mem_stall); end
      nVec++; if (bus.data_req !== 1'b0) begin nErr++; $display("FAIL discard_req%0d got=%b exp=0", c, bus.data_req); end
    end
    @(negedge clk);
    bus.data_data_ok = 0; memenM = 0; stallM = 0;
    #1;
    nVec++; if (mem_stall !== 1'b0) begin nErr++; $display("FAIL discard_release got=%b exp=0", mem_stall); end
    nVec++; if (readdataM !== expBuf) begin nErr++; $display("FAIL discard_dropped got=%h exp=%h", readdataM, expBuf); end
    // Stray data_ok while idle must be ignored.
    @(negedge clk);
    bus.data_data_ok = 1; bus.data_rdata = ~expBuf;
    @(negedge clk);
    bus.data_data_ok = 0;
    #1;
    nVec++; if (readdataM !== expBuf) begin nErr++; $display("FAIL idle_dataok got=%h exp=%h", readdataM, expBuf); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    memenM = 1; memwriteM = 0; sizeM = 2'd2; signedloadM = 0; aluoutM = 32'h400;
    stallM = 1; flushM = 0; bus.data_addr_ok = 1;
    @(negedge clk);
    bus.data_addr_ok = 0;
    #1;
    nVec++; if (mem_stall !== 1'b1) begin nErr++; $display("FAIL rstmid_pre got=%b exp=1", mem_stall); end
    #1 rst = 1;
    #1;
    nVec++; if (mem_stall !== 1'b0 || bus.data_req !== 1'b0) begin nErr++; $display("FAIL rstmid_ctl got=stall%b/req%b exp=0/0", mem_stall, bus.data_req); end
    nVec++; if (readdataM !== 32'h0 || adelM !== 1'b0 || adesM !== 1'b0) begin nErr++; $display("FAIL rstmid_out got=%h/%b/%b exp=0", readdataM, adelM, adesM); end
    @(negedge clk);
    rst = 0; memenM = 0; stallM = 0;
    expBuf = 32'h0;
    #1;
    nVec++; if (mem_stall !== 1'b0 || readdataM !== 32'h0) begin nErr++; $display("FAIL rstmid_after got=%b/%h exp=0/0", mem_stall, readdataM); end
  endtask

  task automatic test_random();
    logic [1:0]  sz;
    logic [31:0] addr;
    for (int i = 0; i < 30; i++) begin
      sz   = 2'($urandom_range(0, 2));
      addr = $urandom();
      if (sz == 2'd1) addr[0] = 1'b0;
      if (sz == 2'd2) addr[1:0] = 2'b00;
      run_xfer($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
               addr, $urandom(), $urandom(),
               $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_misaligned_all();
    test_discard();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
